pipe_hazard_ctrl: RTL and testbench

Parametrised hazard, forwarding and flush controller for the pipelined MIPS datapath. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It tracks every in-flight register write in a scoreboard shift register and drives these signals:
- PC/IF-ID write enables and the ID/EX bubble (load-use stall)
- per-stage flushes (taken branch, jump, jr)
- EX operand forwarding selects and ID read-bypass selects

It replaces ad-hoc stage wiring with one block whose depth, load latency and branch-resolution stage are parameters. Saturating stall/flush event counters are included for performance debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl_scoreboard.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

    // EX operand forwarding selects
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // Scoreboard register fields are stored at a fixed width; narrower
    // register addresses are zero-extended so comparisons stay exact.
    localparam int SB_REG_W = 8;
    localparam logic [SB_REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                valid;
        logic                regwrite;
        logic                memread;
        logic [SB_REG_W-1:0] dst;
        logic [SB_REG_W-1:0] rs;
        logic [SB_REG_W-1:0] rt;
        logic                uses_rs;
        logic                uses_rt;
    } sb_entry_t;

    // An entry is a hazard source only if it will really write a non-zero register.
    function automatic logic writes_reg(sb_entry_t e);
        return e.valid && e.regwrite && (e.dst != REG_ZERO);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side inputs and control outputs of the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W    = 5,
    parameter int BR_STAGE = 2,
    parameter int CNT_W    = 16
);
    logic             ID_Valid;
    logic [REG_W-1:0] ID_Rs;
    logic [REG_W-1:0] ID_Rt;
    logic             ID_UsesRs;
    logic             ID_UsesRt;
    logic             ID_RegWrite;
    logic             ID_MemRead;
    logic [REG_W-1:0] ID_Dst;
    logic             ID_Jump;
    logic             EX_Jr;
    logic             Branch_Taken;
    logic             PC_Write;
    logic             IFID_Write;
    logic             IDEX_Bubble;
    logic [BR_STAGE:0] Flush;
    logic [1:0]       Fwd_A;
    logic [1:0]       Fwd_B;
    logic             ID_Byp_A;
    logic             ID_Byp_B;
    logic [CNT_W-1:0] Stall_Cnt;
    logic [CNT_W-1:0] Flush_Cnt;

    // Datapath side: supplies decode/branch info, consumes controls
    modport master (
        output ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_RegWrite,
               ID_MemRead, ID_Dst, ID_Jump, EX_Jr, Branch_Taken,
        input  PC_Write, IFID_Write, IDEX_Bubble, Flush, Fwd_A, Fwd_B,
               ID_Byp_A, ID_Byp_B, Stall_Cnt, Flush_Cnt
    );

    // Controller side
    modport slave (
        input  ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_RegWrite,
               ID_MemRead, ID_Dst, ID_Jump, EX_Jr, Branch_Taken,
        output PC_Write, IFID_Write, IDEX_Bubble, Flush, Fwd_A, Fwd_B,
               ID_Byp_A, ID_Byp_B, Stall_Cnt, Flush_Cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Shift register of in-flight instructions: entry 1 = EX, 2 = MEM, 3 = WB, ...
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  sb_entry_t                    ins_entry,
    input  logic                         insert_bubble,
    input  logic [NUM_STAGES-1:1]        inval_mask,   // bit k kills entry k as it moves on
    output sb_entry_t [NUM_STAGES:1]     entries
);

    sb_entry_t [NUM_STAGES:1] sb_reg;

    // Entry 1 takes the ID instruction, or a hole when ID/EX is bubbled or flushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sb_reg[1] <= '0;
        else
            sb_reg[1] <= insert_bubble ? '0 : ins_entry;
    end

    for (genvar gi = 2; gi <= NUM_STAGES; gi++) begin : g_shift
        // Older entries advance one stage, squashed when the flush mask says so
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                sb_reg[gi] <= '0;
            else
                sb_reg[gi] <= inval_mask[gi-1] ? '0 : sb_reg[gi-1];
        end
    end

    assign entries = sb_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, EX forwarding, ID bypass and flush control for the pipeline.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int BR_STAGE   = 2,
    parameter int CNT_W      = 16
) (
    input logic              Clk,
    input logic              Reset,
    pipe_hazard_ctrl_if.slave bus
);

    sb_entry_t [NUM_STAGES:1] sb;
    sb_entry_t                ins_entry;
    logic [NUM_STAGES-1:1]    inval_mask;
    logic [SB_REG_W-1:0]      id_rs;
    logic [SB_REG_W-1:0]      id_rt;
    logic                     load_use;
    logic [BR_STAGE:0]        flush_raw;
    logic [BR_STAGE:0]        flush;
    logic                     bubble;
    logic [CNT_W-1:0]         stall_cnt_reg;
    logic [CNT_W-1:0]         flush_cnt_reg;
    logic                     unused_sb;

    assign id_rs = SB_REG_W'(bus.ID_Rs);
    assign id_rt = SB_REG_W'(bus.ID_Rt);

    // Pack the decoded ID instruction into a scoreboard entry
    always_comb begin
        ins_entry          = '0;
        ins_entry.valid    = bus.ID_Valid;
        ins_entry.regwrite = bus.ID_RegWrite;
        ins_entry.memread  = bus.ID_MemRead;
        ins_entry.dst      = SB_REG_W'(bus.ID_Dst);
        ins_entry.rs       = id_rs;
        ins_entry.rt       = id_rt;
        ins_entry.uses_rs  = bus.ID_UsesRs;
        ins_entry.uses_rt  = bus.ID_UsesRt;
    end

    // Instructions younger than a taken branch are squashed as they advance
    for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_inval
        assign inval_mask[gi] = bus.Branch_Taken && (gi < BR_STAGE);
    end

    pipe_scoreboard #(.NUM_STAGES(NUM_STAGES)) u_sb (
        .clk           (Clk),
        .rst_n         (Reset),
        .ins_entry     (ins_entry),
        .insert_bubble (bubble || flush[1]),
        .inval_mask    (inval_mask),
        .entries       (sb)
    );

    // Load-use: a load still in its latency window writes a register ID reads
    always_comb begin
        load_use = 1'b0;
        for (int k = 1; k <= LOAD_LAT; k++) begin
            if (writes_reg(sb[k]) && sb[k].memread &&
                ((bus.ID_UsesRs && sb[k].dst == id_rs) ||
                 (bus.ID_UsesRt && sb[k].dst == id_rt)))
                load_use = 1'b1;
        end
        load_use = load_use && bus.ID_Valid;
    end

    // Flush vector is the OR of branch, jr and jump; held off while in reset
    always_comb begin
        flush_raw = '0;
        if (bus.Branch_Taken)
            flush_raw = '1;
        if (bus.EX_Jr)
            flush_raw[1:0] = 2'b11;
        if (bus.ID_Jump)
            flush_raw[0] = 1'b1;
        flush = Reset ? flush_raw : '0;
    end

    // A flush redirects fetch, so it always beats a stall
    assign bubble          = load_use && !(|flush);
    assign bus.Flush       = flush;
    assign bus.IDEX_Bubble = bubble;
    assign bus.PC_Write    = !bubble;
    assign bus.IFID_Write  = !bubble;

    // EX forwarding: youngest producer wins; a load in MEM has no data yet
    always_comb begin
        bus.Fwd_A = FWD_RF;
        bus.Fwd_B = FWD_RF;
        if (sb[1].valid) begin
            if (writes_reg(sb[2]) && !sb[2].memread && sb[2].dst == sb[1].rs)
                bus.Fwd_A = FWD_MEM;
            else if (writes_reg(sb[3]) && sb[3].dst == sb[1].rs)
                bus.Fwd_A = FWD_WB;
            if (writes_reg(sb[2]) && !sb[2].memread && sb[2].dst == sb[1].rt)
                bus.Fwd_B = FWD_MEM;
            else if (writes_reg(sb[3]) && sb[3].dst == sb[1].rt)
                bus.Fwd_B = FWD_WB;
        end
    end

    // ID read bypass of the value being written back this cycle
    always_comb begin
        bus.ID_Byp_A = writes_reg(sb[3]) && bus.ID_UsesRs && sb[3].dst == id_rs;
        bus.ID_Byp_B = writes_reg(sb[3]) && bus.ID_UsesRt && sb[3].dst == id_rt;
    end

    // Saturating performance counters
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (bubble && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if ((|flush) && flush_cnt_reg != '1)
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign bus.Stall_Cnt = stall_cnt_reg;
    assign bus.Flush_Cnt = flush_cnt_reg;

    // Not every stored field is consumed in every stage
    assign unused_sb = ^sb;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random stimulus against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

    localparam int NS = 3;
    localparam int LL = 1;
    localparam int BR = 2;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic Clk;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

    pipe_hazard_ctrl_if #(.REG_W(5), .BR_STAGE(BR), .CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.REG_W(5), .NUM_STAGES(NS), .LOAD_LAT(LL), .BR_STAGE(BR), .CNT_W(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model: instructions in flight, index 1 = EX, 2 = MEM, 3 = WB
    bit mv [1:NS];
    bit mrw[1:NS];
    bit mmr[1:NS];
    int mdst[1:NS];
    int mrs[1:NS];
    int mrt[1:NS];
    int m_scnt;
    int m_fcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 1; k <= NS; k++) begin
            mv[k] = 0; mrw[k] = 0; mmr[k] = 0; mdst[k] = 0; mrs[k] = 0; mrt[k] = 0;
        end
        m_scnt = 0;
        m_fcnt = 0;
    endtask

    function automatic bit producer(int k);
        return mv[k] && mrw[k] && mdst[k] != 0;
    endfunction

    // Which stage supplies register src to the instruction in EX
    function automatic int fwd_of(int src);
        if (!mv[1]) return 0;
        for (int k = 2; k <= 3; k++)
            if (producer(k) && mdst[k] == src && !(k == 2 && mmr[k])) return k - 1;
        return 0;
    endfunction

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input bit rw, input bit mr, input int dst);
        bus.ID_Valid    = v;
        bus.ID_Rs       = rs[4:0];
        bus.ID_Rt       = rt[4:0];
        bus.ID_UsesRs   = urs;
        bus.ID_UsesRt   = urt;
        bus.ID_RegWrite = rw;
        bus.ID_MemRead  = mr;
        bus.ID_Dst      = dst[4:0];
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ctl(input bit j, input bit jr, input bit br);
        bus.ID_Jump      = j;
        bus.EX_Jr        = jr;
        bus.Branch_Taken = br;
    endtask

    // One clock: predict, compare, advance model across the edge
    task automatic cyc();
        bit stall;
        int fl;
        bit e_bub;
        int id_rs, id_rt;
        #1;
        id_rs = int'(bus.ID_Rs);
        id_rt = int'(bus.ID_Rt);
        stall = 0;
        if (bus.ID_Valid)
            for (int k = 1; k <= LL; k++)
                if (producer(k) && mmr[k] &&
                    ((bus.ID_UsesRs && mdst[k] == id_rs) || (bus.ID_UsesRt && mdst[k] == id_rt)))
                    stall = 1;
        fl = 0;
        if (bus.Branch_Taken) fl |= (1 << (BR + 1)) - 1;
        if (bus.EX_Jr)        fl |= 3;
        if (bus.ID_Jump)      fl |= 1;
        e_bub = (fl == 0) && stall;
        check("pc_write",   bus.PC_Write,    !e_bub);
        check("ifid_write", bus.IFID_Write,  !e_bub);
        check("bubble",     bus.IDEX_Bubble, e_bub);
        check("flush",      bus.Flush,       fl);
        check("fwd_a",      bus.Fwd_A,       fwd_of(mrs[1]));
        check("fwd_b",      bus.Fwd_B,       fwd_of(mrt[1]));
        check("byp_a",      bus.ID_Byp_A,    producer(3) && bus.ID_UsesRs && mdst[3] == id_rs);
        check("byp_b",      bus.ID_Byp_B,    producer(3) && bus.ID_UsesRt && mdst[3] == id_rt);
        check("stall_cnt",  bus.Stall_Cnt,   m_scnt);
        check("flush_cnt",  bus.Flush_Cnt,   m_fcnt);
        @(posedge Clk);
        if (e_bub && m_scnt < CMAX) m_scnt++;
        if (fl != 0 && m_fcnt < CMAX) m_fcnt++;
        for (int k = NS; k >= 2; k--) begin
            mv[k]  = mv[k-1] && !(bus.Branch_Taken && (k - 1) < BR);
            mrw[k] = mrw[k-1]; mmr[k] = mmr[k-1];
            mdst[k] = mdst[k-1]; mrs[k] = mrs[k-1]; mrt[k] = mrt[k-1];
        end
        mv[1]   = bus.ID_Valid && !e_bub && !fl[1];
        mrw[1]  = bus.ID_RegWrite;
        mmr[1]  = bus.ID_MemRead;
        mdst[1] = int'(bus.ID_Dst);
        mrs[1]  = id_rs;
        mrt[1]  = id_rt;
        @(negedge Clk);
    endtask

    initial begin
        model_reset();
        nop();
        ctl(1, 1, 1);
        Reset = 1'b1;
        #1 Reset = 1'b0;
        #2;
        // Reset values, with flush sources held active
        check("rst_pc_write", bus.PC_Write, 1);
        check("rst_ifid",     bus.IFID_Write, 1);
        check("rst_bubble",   bus.IDEX_Bubble, 0);
        check("rst_flush",    bus.Flush, 0);
        check("rst_fwd_a",    bus.Fwd_A, 0);
        check("rst_fwd_b",    bus.Fwd_B, 0);
        check("rst_byp_a",    bus.ID_Byp_A, 0);
        check("rst_stall",    bus.Stall_Cnt, 0);
        check("rst_flushcnt", bus.Flush_Cnt, 0);
        @(negedge Clk);
        Reset = 1'b1;
        ctl(0, 0, 0);
        cyc();

        // Load-use: lw $2 then add $3,$2,$4
        set_id(1, 1, 0, 1, 0, 1, 1, 2); cyc();
        set_id(1, 2, 4, 1, 1, 1, 0, 3);
        #1 check("lu_pc_write", bus.PC_Write, 0); check("lu_bubble", bus.IDEX_Bubble, 1);
        cyc();
        #1 check("lu_stall_cnt", bus.Stall_Cnt, 1); check("lu_release", bus.PC_Write, 1);
        cyc();
        nop();
        #1 check("lu_fwd_a", bus.Fwd_A, 2); check("lu_fwd_b", bus.Fwd_B, 0);
        cyc();

        // Back-to-back ALU: add $5 then sub $6,$5,$5
        set_id(1, 1, 1, 1, 1, 1, 0, 5); cyc();
        set_id(1, 5, 5, 1, 1, 1, 0, 6);
        #1 check("alu_no_stall", bus.IDEX_Bubble, 0);
        cyc();
        nop();
        #1 check("alu_fwd_a", bus.Fwd_A, 1); check("alu_fwd_b", bus.Fwd_B, 1);
        cyc();
        // Write to $0 never forwards
        set_id(1, 1, 1, 1, 1, 1, 0, 0); cyc();
        set_id(1, 0, 0, 1, 1, 1, 0, 6); cyc();
        nop();
        #1 check("r0_fwd_a", bus.Fwd_A, 0); check("r0_fwd_b", bus.Fwd_B, 0);
        cyc();

        // Double match on $7: MEM copy is younger
        set_id(1, 1, 1, 1, 1, 1, 0, 7); cyc();
        cyc();
        set_id(1, 7, 1, 1, 1, 1, 0, 8); cyc();
        nop();
        #1 check("dbl_fwd_a", bus.Fwd_A, 1);
        cyc();

        // Branch taken during a load-use stall
        set_id(1, 1, 0, 1, 0, 1, 1, 2); cyc();
        set_id(1, 2, 0, 1, 0, 1, 0, 3);
        ctl(0, 0, 1);
        #1 check("br_flush", bus.Flush, 7); check("br_pc_write", bus.PC_Write, 1);
        check("br_bubble", bus.IDEX_Bubble, 0);
        cyc();
        nop();
        ctl(0, 0, 0);
        #1 check("br_flush_cnt", bus.Flush_Cnt, 1); check("br_stall_cnt", bus.Stall_Cnt, 1);
        cyc();

        // Jump, jr, and both jr and branch together
        ctl(1, 0, 0); #1 check("jump_flush", bus.Flush, 1); cyc();
        ctl(0, 1, 0); #1 check("jr_flush", bus.Flush, 3); cyc();
        ctl(0, 1, 1); #1 check("jr_br_flush", bus.Flush, 7); cyc();
        ctl(0, 0, 0);

        // WB writes $9 while ID reads $9
        set_id(1, 1, 1, 1, 1, 1, 0, 9); cyc();
        nop(); cyc();
        cyc();
        set_id(1, 9, 0, 1, 0, 0, 0, 0);
        #1 check("byp_a_wb", bus.ID_Byp_A, 1); check("byp_b_wb", bus.ID_Byp_B, 0);
        cyc();

        // Reset asserted mid-stall with a full scoreboard
        set_id(1, 1, 0, 1, 0, 1, 1, 2); cyc();
        set_id(1, 1, 0, 1, 0, 1, 1, 3); cyc();
        set_id(1, 1, 0, 1, 0, 1, 1, 4); cyc();
        set_id(1, 4, 0, 1, 0, 1, 0, 5);
        #1 check("pre_rst_bubble", bus.IDEX_Bubble, 1);
        #1 Reset = 1'b0;
        ctl(0, 1, 1);
        #1;
        check("mid_rst_pc_write", bus.PC_Write, 1);
        check("mid_rst_ifid",     bus.IFID_Write, 1);
        check("mid_rst_bubble",   bus.IDEX_Bubble, 0);
        check("mid_rst_flush",    bus.Flush, 0);
        check("mid_rst_fwd_a",    bus.Fwd_A, 0);
        check("mid_rst_stall",    bus.Stall_Cnt, 0);
        check("mid_rst_flushcnt", bus.Flush_Cnt, 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        ctl(0, 0, 0);

        // lw $2,0($2) repeated: a stall every other cycle, 20 in total
        set_id(1, 2, 0, 1, 0, 1, 1, 2);
        repeat (40) cyc();
        #1 check("sat_stall_cnt", bus.Stall_Cnt, CMAX);

        // Random traffic over a small register range to provoke hazards
        repeat (400) begin
            set_id($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 7));
            ctl($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
